if_stage: RTL and testbench

Instruction-fetch stage for the pipelined LoongArch core. It owns the PC, drives the synchronous instruction SRAM, and delivers `{pc, inst}` pairs to the decode stage under a valid/allowin handshake. It accepts a one-cycle branch redirect from decode and discards the wrong-path instruction. It holds the fetched instruction stable across decode back-pressure.

---
 rtl/if_stage.sv | 95 +++++++++
 tb/tb_if_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch for the pipelined LoongArch core; owns the PC, drives the sync inst SRAM.
// Define IF_INST_BUF_EN to build the stall buffer; otherwise the SRAM must hold its output while disabled.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
);

  // state | meaning
  // EMPTY | nothing in IF (fs_valid = 0)
  // LIVE  | instruction valid, fs_inst taken straight from the SRAM
  // HELD  | instruction valid, fs_inst taken from inst_buf during a stall
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LIVE  = 2'd1,
    HELD  = 2'd2
  } fs_state_t;

  fs_state_t   state_q, state_d;
  logic        fs_valid;
  logic        fs_allowin;
  logic        stall_capture;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;

  assign fs_valid      = (state_q != EMPTY);
  assign seq_pc        = fs_pc + 32'd4;
  assign nextpc        = br_taken ? br_target : seq_pc;
  // A redirect always frees IF, even against decode back-pressure.
  assign fs_allowin    = !fs_valid || ds_allowin || br_taken;
  assign stall_capture = (state_q == LIVE) && !fs_allowin;

  assign inst_sram_en    = !reset && fs_allowin;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'd0;

  // The instruction present during a redirect or reset is never handed over.
  assign fs_to_ds_valid = fs_valid && !br_taken && !reset;

  always_comb begin
    state_d = state_q;
    if (inst_sram_en) begin
      state_d = LIVE;
    end
`ifdef IF_INST_BUF_EN
    else if (stall_capture) begin
      state_d = HELD;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      fs_pc   <= RESET_PC - 32'd4;
    end else begin
      state_q <= state_d;
      if (inst_sram_en) begin
        fs_pc <= nextpc;
      end
    end
  end

`ifdef IF_INST_BUF_EN
  logic [31:0] inst_buf;
  logic        inst_buf_valid;

  assign inst_buf_valid = (state_q == HELD);

  // Only the first stall cycle captures; the SRAM output may drift once disabled.
  always_ff @(posedge clk) begin
    if (stall_capture) begin
      inst_buf <= inst_sram_rdata;
    end
  end

  assign fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata;
`else
  assign fs_inst = inst_sram_rdata;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plus random-back-pressure bench for if_stage with a scoreboard of expected transfers.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk;
  logic        reset;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;
  int xfer_before_rand;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_pc           (fs_pc),
    .fs_inst         (fs_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h02800000 + ((a - RST_PC) >> 2);
  endfunction

  // Synchronous SRAM; garbage while disabled only when the buffer exists to cover it.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
`ifdef IF_INST_BUF_EN
    else inst_sram_rdata <= 32'hdeadbeef;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    br_taken  = 1'b1;
    br_target = tgt;
    exp_q.delete();
    exp_q.push_back(tgt);
  endtask

  // Scoreboard: every handshake must match the head of the expected pc stream.
  always @(negedge clk) begin
    if (fs_to_ds_valid === 1'b1 && ds_allowin === 1'b1) begin
      n_xfer++;
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL xfer_unexpected: observed pc %h expected no transfer", fs_pc);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("xfer_pc", fs_pc, mon_e);
        chk("xfer_inst", fs_inst, mem_word(mon_e));
        exp_q.push_back(mon_e + 32'd4);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    ds_allowin = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'd0;

    step();
    step();
    @(negedge clk);
    chk("rst_en", {31'd0, inst_sram_en}, 32'd0);
    chk("rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    chk("rst_pc", fs_pc, RST_PC - 32'd4);

    step();
    reset = 1'b0;
    exp_q.push_back(RST_PC);
    @(negedge clk);
    chk("first_en", {31'd0, inst_sram_en}, 32'd1);
    chk("first_addr", inst_sram_addr, RST_PC);
    chk("first_valid", {31'd0, fs_to_ds_valid}, 32'd0);

    step();
    @(negedge clk);
    chk("pc0_valid", {31'd0, fs_to_ds_valid}, 32'd1);
    chk("pc0_pc", fs_pc, 32'h1c000000);
    chk("pc0_inst", fs_inst, 32'h02800000);
    chk("pc0_addr", inst_sram_addr, 32'h1c000004);

    step();
    @(negedge clk);
    chk("pc1_pc", fs_pc, 32'h1c000004);
    chk("pc1_inst", fs_inst, 32'h02800001);

    // three-cycle decode stall at pc 0x1c000008
    step();
    ds_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_pc", fs_pc, 32'h1c000008);
      chk("stall_inst", fs_inst, 32'h02800002);
      chk("stall_en", {31'd0, inst_sram_en}, 32'd0);
      chk("stall_valid", {31'd0, fs_to_ds_valid}, 32'd1);
      if (i < 2) step();
    end
    step();
    ds_allowin = 1'b1;
    @(negedge clk);
    chk("unstall_pc", fs_pc, 32'h1c000008);
    chk("unstall_addr", inst_sram_addr, 32'h1c00000c);
    step();
    @(negedge clk);
    chk("after_stall_pc", fs_pc, 32'h1c00000c);
    chk("after_stall_inst", fs_inst, 32'h02800003);

    // redirect while 0x1c000010 is presented
    step();
    redirect(32'h1c000100);
    @(negedge clk);
    chk("br_pc_shown", fs_pc, 32'h1c000010);
    chk("br_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    chk("br_en", {31'd0, inst_sram_en}, 32'd1);
    chk("br_addr", inst_sram_addr, 32'h1c000100);
    step();
    br_taken = 1'b0;
    @(negedge clk);
    chk("tgt_pc", fs_pc, 32'h1c000100);
    chk("tgt_inst", fs_inst, mem_word(32'h1c000100));
    chk("tgt_valid", {31'd0, fs_to_ds_valid}, 32'd1);

    // redirect in the second cycle of a stall
    step();
    ds_allowin = 1'b0;
    @(negedge clk);
    chk("bs_en", {31'd0, inst_sram_en}, 32'd0);
    step();
    redirect(32'h1c000200);
    @(negedge clk);
    chk("bs_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    chk("bs_en2", {31'd0, inst_sram_en}, 32'd1);
    chk("bs_addr", inst_sram_addr, 32'h1c000200);
    step();
    br_taken   = 1'b0;
    ds_allowin = 1'b1;
    @(negedge clk);
    chk("bs_tgt_pc", fs_pc, 32'h1c000200);
    chk("bs_tgt_inst", fs_inst, mem_word(32'h1c000200));
    chk("bs_tgt_valid", {31'd0, fs_to_ds_valid}, 32'd1);

    // one-cycle reset in the middle of a stall
    step();
    ds_allowin = 1'b0;
    @(negedge clk);
    chk("rs_stall_en", {31'd0, inst_sram_en}, 32'd0);
    step();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rs_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    chk("rs_en", {31'd0, inst_sram_en}, 32'd0);
    step();
    reset      = 1'b0;
    ds_allowin = 1'b1;
    exp_q.push_back(RST_PC);
    @(negedge clk);
    chk("rs_empty_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    chk("rs_empty_pc", fs_pc, RST_PC - 32'd4);
    chk("rs_restart_addr", inst_sram_addr, RST_PC);
    step();
    @(negedge clk);
    chk("rs_restart_pc", fs_pc, RST_PC);
    chk("rs_restart_inst", fs_inst, 32'h02800000);

    // random back-pressure with occasional redirects
    xfer_before_rand = n_xfer;
    for (int i = 0; i < 400; i++) begin
      step();
      ds_allowin = ($urandom_range(0, 3) != 0);
      if (!br_taken && $urandom_range(0, 15) == 0)
        redirect(RST_PC + ($urandom_range(0, 255) << 2));
      else
        br_taken = 1'b0;
    end
    step();
    br_taken   = 1'b0;
    ds_allowin = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("rand_progress", {31'd0, (n_xfer - xfer_before_rand) > 150}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
